accumulator_unit: RTL and testbench

ACCUMULATOR_UNIT -- requirements
Module: accumulator_unit

---
 rtl/accumulator_unit.sv | 180 ++++++++++++++++++
 tb/tb_accumulator_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_unit.sv
// Command-driven accumulator: LOAD/ADD/SUB/CLEAR with repeat count and carry chaining; result is valid N cycles after accept.
// Accepts only in IDLE; a result holds in DONE until OUT_READY, and commands are ignored outside IDLE.

module adder_and_subtractor #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  SUB,
   input  logic                  CI,
   output logic [DATA_WIDTH-1:0] S,
   output logic                  CO
);
   logic [DATA_WIDTH-1:0] w_b;
   logic                  w_cin;
   logic [DATA_WIDTH:0]   w_sum;

   // SUB is A + ~B + !CI, so the raw carry-out is the inverse of the borrow
   assign w_b   = SUB ? ~B : B;
   assign w_cin = SUB ? ~CI : CI;
   assign w_sum = {1'b0, A} + {1'b0, w_b} + {{DATA_WIDTH{1'b0}}, w_cin};
   assign S     = w_sum[DATA_WIDTH-1:0];
   assign CO    = SUB ? ~w_sum[DATA_WIDTH] : w_sum[DATA_WIDTH];
endmodule

module accumulator_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [1:0]            OP,
   input  logic [DATA_WIDTH-1:0] DIN,
   input  logic [CNT_WIDTH-1:0]  CNT,
   input  logic                  USE_CARRY,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [DATA_WIDTH-1:0] ACC,
   output logic                  C,
   output logic                  Z,
   output logic                  N,
   output logic                  V
);
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;
   localparam logic [CNT_WIDTH-1:0] REM_ONE = CNT_WIDTH'(1);
   localparam int MSB = DATA_WIDTH - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [1:0]            r_op;
   logic [DATA_WIDTH-1:0] r_din;
   logic                  r_use_carry;
   logic [CNT_WIDTH-1:0]  r_rem;
   logic [DATA_WIDTH-1:0] r_acc;
   logic                  r_c;
   logic                  r_z;
   logic                  r_n;
   logic                  r_v;
   logic                  r_in_ready;
   logic                  r_out_valid;

   logic                  w_sub;
   logic                  w_ci;
   logic [DATA_WIDTH-1:0] w_s;
   logic                  w_co;
   logic [DATA_WIDTH-1:0] w_b_eff;
   logic                  w_ovf;
   logic [DATA_WIDTH-1:0] w_acc_next;
   logic                  w_arith;
   logic                  w_in_arith;
   logic [CNT_WIDTH-1:0]  w_rem_init;

   assign w_sub = (r_op == OP_SUB);
   assign w_ci  = r_use_carry & r_c;

   adder_and_subtractor #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_addsub (
      .A  (r_acc),
      .B  (r_din),
      .SUB(w_sub),
      .CI (w_ci),
      .S  (w_s),
      .CO (w_co)
   );

   assign w_b_eff = w_sub ? ~r_din : r_din;
   assign w_ovf   = (r_acc[MSB] == w_b_eff[MSB]) && (w_s[MSB] != r_acc[MSB]);
   assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

   assign w_in_arith = (OP == OP_ADD) || (OP == OP_SUB);
   assign w_rem_init = (w_in_arith && (CNT != '0)) ? CNT : REM_ONE;

   always_comb begin
      w_acc_next = r_acc;
      case (r_op)
         OP_LOAD:  w_acc_next = r_din;
         OP_CLEAR: w_acc_next = '0;
         default:  w_acc_next = w_s;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_op        <= OP_LOAD;
         r_din       <= '0;
         r_use_carry <= 1'b0;
         r_rem       <= '0;
         r_acc       <= '0;
         r_c         <= 1'b0;
         r_z         <= 1'b1;
         r_n         <= 1'b0;
         r_v         <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (IN_VALID) begin
                  r_op        <= OP;
                  r_din       <= DIN;
                  r_use_carry <= USE_CARRY;
                  r_rem       <= w_rem_init;
                  r_in_ready  <= 1'b0;
                  r_state     <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_acc <= w_acc_next;
               r_z   <= (w_acc_next == '0);
               r_n   <= w_acc_next[MSB];
               if (w_arith) begin
                  r_c <= w_co;
                  r_v <= w_ovf;
               end else begin
                  r_c <= 1'b0;
                  r_v <= 1'b0;
               end
               r_rem <= r_rem - REM_ONE;
               if (r_rem == REM_ONE) begin
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               // Release goes to IDLE only; a command offered this cycle waits for the next edge
               if (OUT_READY) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign IN_READY  = r_in_ready;
   assign OUT_VALID = r_out_valid;
   assign ACC       = r_acc;
   assign C         = r_c;
   assign Z         = r_z;
   assign N         = r_n;
   assign V         = r_v;
endmodule

// File: tb/tb_accumulator_unit.sv
// Randomised and directed bench for accumulator_unit (DATA_WIDTH=8, CNT_WIDTH=4) against an integer model.
module tb_accumulator_unit;
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       IN_VALID = 1'b0;
   logic       IN_READY;
   logic [1:0] OP = 2'b00;
   logic [7:0] DIN = 8'd0;
   logic [3:0] CNT = 4'd0;
   logic       USE_CARRY = 1'b0;
   logic       OUT_VALID;
   logic       OUT_READY = 1'b0;
   logic [7:0] ACC;
   logic       C, Z, N, V;

   int total = 0;
   int bad   = 0;

   int m_acc = 0;
   bit m_c = 0, m_z = 1, m_n = 0, m_v = 0;

   accumulator_unit #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .OP(OP), .DIN(DIN), .CNT(CNT), .USE_CARRY(USE_CARRY),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .ACC(ACC), .C(C), .Z(Z), .N(N), .V(V)
   );

   always #5 CLK = ~CLK;

   function automatic int s8(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   function automatic int iters(input logic [1:0] op, input int cnt);
      if (op == 2'b01 || op == 2'b10) return (cnt == 0) ? 1 : cnt;
      return 1;
   endfunction

   // Reference: plain integer arithmetic, one repeat at a time
   task automatic model_apply(input logic [1:0] op, input int din, input int cnt, input bit uc);
      int t, st, ci;
      case (op)
         2'b00: begin m_acc = din; m_c = 0; m_v = 0; end
         2'b11: begin m_acc = 0;   m_c = 0; m_v = 0; end
         default: begin
            for (int i = 0; i < iters(op, cnt); i++) begin
               ci = (uc && m_c) ? 1 : 0;
               if (op == 2'b01) begin
                  t  = m_acc + din + ci;
                  m_c = (t > 255);
                  st = s8(m_acc) + s8(din) + ci;
               end else begin
                  t  = m_acc - din - ci;
                  m_c = (t < 0);
                  st = s8(m_acc) - s8(din) - ci;
               end
               m_v   = (st > 127) || (st < -128);
               m_acc = t & 255;
            end
         end
      endcase
      m_z = (m_acc == 0);
      m_n = (m_acc >= 128);
   endtask

   task automatic model_reset();
      m_acc = 0; m_c = 0; m_z = 1; m_n = 0; m_v = 0;
   endtask

   // Issues one command and waits for OUT_VALID; lat<0 means IN_READY or OUT_VALID never came
   task automatic run_cmd(input logic [1:0] op, input int din, input int cnt, input bit uc, output int lat);
      int w;
      lat = -1;
      @(negedge CLK);
      w = 0;
      while (!IN_READY && w < 20) begin @(negedge CLK); w++; end
      if (!IN_READY) begin lat = -2; return; end
      OP = op; DIN = din[7:0]; CNT = cnt[3:0]; USE_CARRY = uc; IN_VALID = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      IN_VALID = 1'b0;
      model_apply(op, din, cnt, uc);
      for (int k = 1; k <= 40; k++) begin
         OP = 2'($urandom); DIN = 8'($urandom); CNT = 4'($urandom); USE_CARRY = 1'($urandom);
         @(posedge CLK);
         @(negedge CLK);
         if (OUT_VALID) begin lat = k; break; end
      end
   endtask

   task automatic release_out();
      OUT_READY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      OUT_READY = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      total++; if (ACC !== 8'd0) begin bad++; $display("FAIL reset_acc got=%0d exp=0", ACC); end
      total++; if ({C,Z,N,V} !== 4'b0100) begin bad++; $display("FAIL reset_flags got=%b exp=0100", {C,Z,N,V}); end
      total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
      total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", OUT_VALID); end
      RST = 1'b0;
      model_reset();
   endtask

   task automatic test_add_basic();
      int lat;
      run_cmd(2'b00, 100, 0, 0, lat); release_out();
      run_cmd(2'b01, 16, 1, 0, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d exp=1", lat); end
      total++; if (ACC !== 8'd116) begin bad++; $display("FAIL add_acc got=%0d exp=116", ACC); end
      total++; if ({C,Z} !== 2'b00) begin bad++; $display("FAIL add_cz got=%b exp=00", {C,Z}); end
      release_out();
      run_cmd(2'b01, 0, 1, 0, lat);
      total++; if (ACC !== 8'd116) begin bad++; $display("FAIL add_zero got=%0d exp=116", ACC); end
      release_out();
   endtask

   task automatic test_carry_chain();
      int lat;
      run_cmd(2'b00, 200, 0, 0, lat); release_out();
      run_cmd(2'b01, 200, 1, 0, lat);
      total++; if (ACC !== 8'd144 || {C,N,V} !== 3'b110) begin bad++; $display("FAIL carry_out got=%0d/%b exp=144/110", ACC, {C,N,V}); end
      release_out();
      run_cmd(2'b01, 0, 1, 1, lat);
      total++; if (ACC !== 8'd145 || C !== 1'b0) begin bad++; $display("FAIL carry_in got=%0d/%b exp=145/0", ACC, C); end
      release_out();
   endtask

   task automatic test_sub();
      int lat;
      run_cmd(2'b00, 8, 0, 0, lat); release_out();
      run_cmd(2'b10, 12, 1, 0, lat);
      total++; if (ACC !== 8'd252 || {C,N,V} !== 3'b110) begin bad++; $display("FAIL sub_borrow got=%0d/%b exp=252/110", ACC, {C,N,V}); end
      release_out();
      run_cmd(2'b00, 200, 0, 0, lat); release_out();
      run_cmd(2'b10, 200, 1, 0, lat);
      total++; if (ACC !== 8'd0 || {C,Z} !== 2'b01) begin bad++; $display("FAIL sub_zero got=%0d/%b exp=0/01", ACC, {C,Z}); end
      release_out();
   endtask

   task automatic test_backpressure();
      int lat;
      run_cmd(2'b00, 0, 0, 0, lat); release_out();
      run_cmd(2'b01, 25, 4, 0, lat);
      total++; if (lat !== 4 || ACC !== 8'd100) begin bad++; $display("FAIL repeat4 got=lat%0d/%0d exp=lat4/100", lat, ACC); end
      OP = 2'b00; DIN = 8'd55; IN_VALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); @(negedge CLK);
         total++;
         if (ACC !== 8'd100 || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
            bad++; $display("FAIL hold_%0d got=%0d/%b%b exp=100/10", i, ACC, OUT_VALID, IN_READY);
         end
      end
      IN_VALID = 1'b0;
      release_out();
      total++; if (ACC !== 8'd100 || IN_READY !== 1'b1) begin bad++; $display("FAIL not_consumed got=%0d/%b exp=100/1", ACC, IN_READY); end
      run_cmd(2'b00, 127, 0, 0, lat); release_out();
      run_cmd(2'b01, 1, 1, 0, lat);
      total++; if (ACC !== 8'd128 || {C,Z,N,V} !== 4'b0011) begin bad++; $display("FAIL overflow got=%0d/%b exp=128/0011", ACC, {C,Z,N,V}); end
      release_out();
   endtask

   task automatic test_done_handoff();
      int lat;
      run_cmd(2'b11, 0, 0, 0, lat);
      total++; if (ACC !== 8'd0 || {C,Z,N,V} !== 4'b0100) begin bad++; $display("FAIL clear got=%0d/%b exp=0/0100", ACC, {C,Z,N,V}); end
      OP = 2'b00; DIN = 8'd9; IN_VALID = 1'b1; OUT_READY = 1'b1;
      @(posedge CLK); @(negedge CLK);
      IN_VALID = 1'b0; OUT_READY = 1'b0;
      total++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin bad++; $display("FAIL handoff got=%b%b exp=10", IN_READY, OUT_VALID); end
      @(posedge CLK); @(negedge CLK);
      total++; if (ACC !== 8'd0 || IN_READY !== 1'b1) begin bad++; $display("FAIL handoff_idle got=%0d/%b exp=0/1", ACC, IN_READY); end
   endtask

   task automatic test_reset_abort();
      int lat;
      bit seen;
      run_cmd(2'b00, 50, 0, 0, lat); release_out();
      @(negedge CLK);
      OP = 2'b01; DIN = 8'd1; CNT = 4'd10; USE_CARRY = 1'b0; IN_VALID = 1'b1;
      @(posedge CLK); @(negedge CLK);
      IN_VALID = 1'b0;
      repeat (4) begin @(posedge CLK); @(negedge CLK); end
      RST = 1'b1;
      #1;
      total++; if (ACC !== 8'd0 || {C,Z,N,V} !== 4'b0100) begin bad++; $display("FAIL abort_acc got=%0d/%b exp=0/0100", ACC, {C,Z,N,V}); end
      total++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin bad++; $display("FAIL abort_hs got=%b%b exp=10", IN_READY, OUT_VALID); end
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      seen = 0;
      repeat (12) begin @(negedge CLK); if (OUT_VALID) seen = 1; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_result got=%b exp=0", seen); end
      run_cmd(2'b00, 7, 0, 0, lat);
      total++; if (ACC !== 8'd7) begin bad++; $display("FAIL after_abort got=%0d exp=7", ACC); end
      release_out();
   endtask

   task automatic test_random();
      int lat, din, cnt, hold;
      logic [1:0] op;
      bit uc;
      for (int n = 0; n < 40; n++) begin
         op = 2'($urandom_range(3, 0));
         din = $urandom_range(255, 0);
         cnt = $urandom_range(15, 0);
         uc = 1'($urandom);
         run_cmd(op, din, cnt, uc, lat);
         total++;
         if (lat !== iters(op, cnt) || ACC !== m_acc[7:0] || {C,Z,N,V} !== {m_c,m_z,m_n,m_v}) begin
            bad++;
            $display("FAIL rand_%0d op=%0d din=%0d cnt=%0d uc=%0d got=lat%0d/%0d/%b exp=lat%0d/%0d/%b",
                     n, op, din, cnt, uc, lat, ACC, {C,Z,N,V}, iters(op, cnt), m_acc, {m_c,m_z,m_n,m_v});
         end
         hold = $urandom_range(2, 0);
         repeat (hold) begin @(posedge CLK); @(negedge CLK); end
         total++;
         if (OUT_VALID !== 1'b1 || ACC !== m_acc[7:0]) begin
            bad++; $display("FAIL rand_hold_%0d got=%b/%0d exp=1/%0d", n, OUT_VALID, ACC, m_acc);
         end
         release_out();
      end
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_carry_chain();
      test_sub();
      test_backpressure();
      test_done_handoff();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
